// File: rtl/cla_pkg.sv
// Shared types and constants for the serial borrow-lookahead subtractor.
package cla_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the slice index; never narrower than one bit.
  function automatic int idx_w(input int slices);
    return (slices <= 1) ? 1 : $clog2(slices);
  endfunction

endpackage

// File: rtl/cla_sub_slice.sv
// 4-bit combinational borrow-lookahead slice: d = a - b - bin, computed as a + ~b + ~bin.
module cla_sub_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [4:0] c_s;

  assign g_s = a & ~b;
  assign p_s = a ^ ~b;

  // Carries expanded fully so no carry ripples through the slice.
  assign c_s[0] = ~bin;
  assign c_s[1] = g_s[0] | (p_s[0] & c_s[0]);
  assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_s[0]);
  assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & c_s[0]);
  assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_s[0]);

  assign d    = p_s ^ c_s[3:0];
  assign bout = ~c_s[4];

endmodule

// File: rtl/cla_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor, one 4-bit slice per cycle with valid/ready on both sides.
// Optional signed-overflow output Ovf is enabled by defining CLA_SUB_OVF_EN.
module cla_serial_subtractor
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
`ifdef CLA_SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int SLICES = WIDTH / SLICE_W;
  localparam int IW     = idx_w(SLICES);

  state_t           state_r;
  logic [IW-1:0]    idx_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] work_r;
  logic             brw_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;

  logic [SLICE_W-1:0] a_sl_s;
  logic [SLICE_W-1:0] b_sl_s;
  logic [SLICE_W-1:0] d_s;
  logic               bout_s;
  logic [WIDTH-1:0]   work_next_s;
  logic               last_s;

  // Slice selection by shifting keeps the mux free of variable part-selects.
  assign a_sl_s      = SLICE_W'(a_r >> {idx_r, 2'b00});
  assign b_sl_s      = SLICE_W'(b_r >> {idx_r, 2'b00});
  assign work_next_s = work_r | (WIDTH'(d_s) << {idx_r, 2'b00});
  assign last_s      = (idx_r == IW'(SLICES - 1));

  cla_sub_slice u_slice (
    .a    (a_sl_s),
    .b    (b_sl_s),
    .bin  (brw_r),
    .d    (d_s),
    .bout (bout_s)
  );

`ifdef CLA_SUB_OVF_EN
  logic ovf_r;
  assign Ovf = ovf_r;
`endif

  // Control FSM, working datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      a_r         <= '0;
      b_r         <= '0;
      work_r      <= '0;
      brw_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      diff_r      <= '0;
      borrow_r    <= 1'b0;
`ifdef CLA_SUB_OVF_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r        <= A;
            b_r        <= B;
            brw_r      <= Bin;
            idx_r      <= '0;
            work_r     <= '0;
            in_ready_r <= 1'b0;
            state_r    <= BUSY;
          end else begin
            state_r    <= IDLE;
          end
        end
        BUSY: begin
          work_r <= work_next_s;
          brw_r  <= bout_s;
          idx_r  <= idx_r + 1'b1;
          if (last_s) begin
            diff_r      <= work_next_s;
            borrow_r    <= bout_s;
`ifdef CLA_SUB_OVF_EN
            ovf_r       <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (work_next_s[WIDTH-1] != a_r[WIDTH-1]);
`endif
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r     <= BUSY;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r     <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign Diff      = diff_r;
  assign Borrow    = borrow_r;

endmodule

// File: tb/tb_cla_serial_subtractor.sv
// Self-checking bench for cla_serial_subtractor (WIDTH=16) with a result scoreboard.
module tb_cla_serial_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Diff;
  logic         Borrow;
  logic         ovf_s;
`ifdef CLA_SUB_OVF_EN
  logic         Ovf;
  assign ovf_s = Ovf;
`else
  assign ovf_s = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Scoreboard entries: {ovf, borrow, diff}
  logic [W+1:0] sb_q[$];

  always #5 clk = ~clk;

  cla_serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (Diff),
    .Borrow    (Borrow)
`ifdef CLA_SUB_OVF_EN
    ,
    .Ovf       (Ovf)
`endif
  );

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    logic [W:0] r;
    logic       ov;
    r  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    return {ov, r[W], r[W-1:0]};
  endfunction

  // Drive operands for one capture edge; scoreboard entry pushed as stimulus goes in.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input bit push);
    in_valid = 1'b1; A = a; B = b; Bin = bi;
    if (push) sb_q.push_back(model(a, b, bi));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid, check latency and result, then complete the output handshake.
  task automatic finish_op(input string name, input int exp_lat);
    int n;
    logic [W+1:0] exp;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      if (out_valid) break;
      n = i;
      @(posedge clk); #1;
    end
    total++;
    if (!out_valid) begin
      bad++; $display("FAIL %s timeout: out_valid never rose (required within 20 cycles)", name);
      return;
    end
    if (exp_lat > 0) begin
      total++;
      if (n !== exp_lat) begin bad++; $display("FAIL %s latency: got %0d cycles, required %0d", name, n, exp_lat); end
    end
    exp = sb_q.pop_front();
    if (Diff !== exp[W-1:0]) begin bad++; $display("FAIL %s diff: got %h required %h", name, Diff, exp[W-1:0]); end
    total++;
    if (Borrow !== exp[W]) begin bad++; $display("FAIL %s borrow: got %b required %b", name, Borrow, exp[W]); end
`ifdef CLA_SUB_OVF_EN
    total++;
    if (ovf_s !== exp[W+1]) begin bad++; $display("FAIL %s ovf: got %b required %b", name, ovf_s, exp[W+1]); end
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL %s release: in_ready=%b out_valid=%b required 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total++;
    if ({in_ready, out_valid, Borrow, Diff} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      bad++; $display("FAIL reset: in_ready=%b out_valid=%b borrow=%b diff=%h required 1/0/0/0000", in_ready, out_valid, Borrow, Diff);
    end
  endtask

  task automatic test_basic();
    start_op(16'h5A5A, 16'h1234, 1'b0, 1'b1); finish_op("case1", 4);
    start_op(16'h0000, 16'h0001, 1'b0, 1'b1); finish_op("case2", 4);
    start_op(16'h1000, 16'h0FFF, 1'b1, 1'b1); finish_op("case3", 4);
    for (int i = 0; i < 6; i++) begin
      start_op(W'($urandom), W'($urandom), 1'(i), 1'b1); finish_op("random", 4);
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] exp;
    int n;
    start_op(16'h5A5A, 16'h1234, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    exp = sb_q.pop_front();
    in_valid = 1'b1; A = 16'h9999; B = 16'h1111; Bin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (Diff !== exp[W-1:0] || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold: diff=%h in_ready=%b out_valid=%b required %h/0/1", Diff, in_ready, out_valid, exp[W-1:0]);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Diff !== exp[W-1:0]) begin
      bad++; $display("FAIL bp_idle: in_ready=%b out_valid=%b diff=%h required 1/0/%h", in_ready, out_valid, Diff, exp[W-1:0]);
    end
    start_op(16'h9999, 16'h1111, 1'b0, 1'b1);
    finish_op("bp_new", 4);
  endtask

  task automatic test_reset_abort();
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, Borrow, Diff} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      bad++; $display("FAIL abort: in_ready=%b out_valid=%b borrow=%b diff=%h required 1/0/0/0000", in_ready, out_valid, Borrow, Diff);
    end
    start_op(16'h0100, 16'h0200, 1'b0, 1'b1);
    finish_op("after_abort", 4);
  endtask

  task automatic test_ovf();
    start_op(16'h8000, 16'h0001, 1'b0, 1'b1); finish_op("ovf_set", 4);
    start_op(16'h0003, 16'h0001, 1'b0, 1'b1); finish_op("ovf_clr", 4);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Bin = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_abort();
    test_ovf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
